reg_file_write_scheduler: RTL and testbench
===========================================

// Module: reg_file_write_scheduler
// PURPOSE
//  Owns the single write port (WE3/A3/WD3) of wrapper_register_file.
//  - Clears x1..x(2^SIZE-1) to zero after reset.
//  - Arbitrates two write requesters: core write-back (priority) and a debug/loader port.
//  - Starvation guard: the debug port is always granted after STARVE_LIMIT lost cycles.
//  - Write-port outputs are registered and drive the register file directly.
// PARAMETERS
//  WIDTH          32  data width of a register
//  SIZE           5   address width; register file holds 2^SIZE registers
//  CLEAR_ON_RESET 1   1: run zero-clear sweep after reset; 0: go straight to ARB
//  STARVE_LIMIT   4   lost cycles before debug gets a forced grant (>=1)
// PORTS
//  clk                  in   1      rising-edge clock
//  reset                in   1      asynchronous, active-high reset
//  core_we_i            in   1      core write request (valid)
//  core_addr_i          in   SIZE   core destination register
//  core_data_i          in   WIDTH  core write data
//  core_ready_o         out  1      core request accepted this cycle
//  dbg_valid_i          in   1      debug write request
//  dbg_addr_i           in   SIZE   debug destination register
//  dbg_data_i           in   WIDTH  debug write data
//  dbg_ready_o          out  1      debug request accepted this cycle
//  reg_write_WE3_o      out  1      to register file WE3 (registered)
//  write_register_A3_o  out  SIZE   to register file A3 (registered)
//  write_data_WD3_o     out  WIDTH  to register file WD3 (registered)
//  busy_o               out  1      clear sweep in progress
// BEHAVIOUR
//  Reset (async, active-high):
//   - WE3/A3/WD3 = 0; clear_cnt = 1; wait_cnt = 0.
//   - State = CLEAR if CLEAR_ON_RESET, else ARB.
//   - Reset mid-sweep or mid-arbitration aborts everything and restarts from this state.
//  Handshake:
//   - A transfer occurs when valid && ready are both high at a rising edge.
//   - Requesters hold addr/data stable until they see ready.
//   - Ready outputs are combinational from state, wait_cnt and core_we_i.
//   - Latency: the accepted write appears on WE3/A3/WD3 one cycle after the handshake edge, for exactly one cycle.
//  State CLEAR:
//   - busy_o = 1; core_ready_o = 0; dbg_ready_o = 0.
//   - Each edge registers WE3 = 1, A3 = clear_cnt, WD3 = 0, then clear_cnt++.
//   - The edge that issues A3 = 2^SIZE-1 moves the state to ARB.
//   - Sweep length is 2^SIZE-1 cycles (31 for SIZE = 5); x0 is never written.
//  State ARB (busy_o = 0):
//   - Forced slot (wait_cnt == STARVE_LIMIT): dbg_ready_o = 1, core_ready_o = 0.
//   - Otherwise: core_ready_o = 1, dbg_ready_o = !core_we_i.
//   - Core write handshake: WE3 = 1, A3 = core_addr_i, WD3 = core_data_i on the next edge.
//   - Debug write handshake: WE3 = 1, A3 = dbg_addr_i, WD3 = dbg_data_i; wait_cnt cleared.
//   - No handshake: registers WE3 = 0; A3 and WD3 hold their last values.
//   - wait_cnt increments (saturating at STARVE_LIMIT) each edge with dbg_valid_i && !dbg_ready_o.
//   - wait_cnt is cleared on a debug handshake or when dbg_valid_i = 0.
//  Address 0:
//   - A request to address 0 completes its handshake normally.
//   - WE3 stays 0 for that slot (x0 is hard-wired).
//  Simultaneous requests: the core wins unless the forced slot is active; at most one write per cycle.
// TESTING
//  T1 reset high 3 cycles, then low -> WE3=1 with A3=1..31 and WD3=0 on 31 consecutive cycles; busy_o falls after A3=31; both readies 0 during the sweep.
//  T2 ARB: core_we_i=1, addr=2, data=7 -> core_ready_o=1; next cycle WE3=1, A3=2, WD3=7; the register file then reads 7 on RD1 with A1=2.
//  T3 core_we_i=1 continuously and dbg_valid_i=1 (addr=4, data=20) -> dbg_ready_o=0 for 4 cycles, then 1 for 1 cycle with core_ready_o=0; next cycle A3=4, WD3=20.
//  T4 core write to addr 0 with data 0xFFFF_FFFF -> core_ready_o=1, WE3 stays 0; RD of x0 remains 0.
//  T5 assert reset mid-sweep (at A3=10) -> outputs 0 immediately; after release the sweep restarts at A3=1.
//  T6 CLEAR_ON_RESET=0 -> busy_o=0 from reset; a debug write (addr=31, data=6) is accepted on the first cycle after release.

Source files
------------

// File: rtl/reg_file_write_scheduler.sv
// Owns the register-file write port: zero-clears x1..xN after reset, then arbitrates core (priority) vs debug writes.
// Latency: an accepted write appears on WE3/A3/WD3 one cycle after the handshake edge, for one cycle.
// Backpressure: readies drop during the sweep; debug waits behind core but gets a forced slot after STARVE_LIMIT lost cycles.
module reg_file_write_scheduler #(
    parameter int WIDTH          = 32,
    parameter int SIZE           = 5,
    parameter int CLEAR_ON_RESET = 1,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             core_we_i,
    input  logic [SIZE-1:0]  core_addr_i,
    input  logic [WIDTH-1:0] core_data_i,
    output logic             core_ready_o,
    input  logic             dbg_valid_i,
    input  logic [SIZE-1:0]  dbg_addr_i,
    input  logic [WIDTH-1:0] dbg_data_i,
    output logic             dbg_ready_o,
    output logic             reg_write_WE3_o,
    output logic [SIZE-1:0]  write_register_A3_o,
    output logic [WIDTH-1:0] write_data_WD3_o,
    output logic             busy_o
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT     = CW'(STARVE_LIMIT);
    localparam logic [SIZE-1:0] LAST_ADDR = {SIZE{1'b1}};

    typedef enum logic {ST_CLEAR, ST_ARB} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;

    state_t            state, state_nxt;
    logic [SIZE-1:0]   clear_cnt, clear_cnt_nxt;
    logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
    logic              we_nxt;
    logic [SIZE-1:0]   a3_nxt;
    logic [WIDTH-1:0]  wd3_nxt;
    logic              forced;
    logic              core_hs;
    logic              dbg_hs;

    assign busy_o = (state == ST_CLEAR);
    assign forced = (wait_cnt == LIMIT);

    always_comb begin
        state_nxt     = state;
        clear_cnt_nxt = clear_cnt;
        wait_cnt_nxt  = wait_cnt;
        we_nxt        = 1'b0;
        a3_nxt        = write_register_A3_o;
        wd3_nxt       = write_data_WD3_o;
        core_ready_o  = 1'b0;
        dbg_ready_o   = 1'b0;
        core_hs       = 1'b0;
        dbg_hs        = 1'b0;
        case (state)
            ST_CLEAR: begin
                we_nxt        = 1'b1;
                a3_nxt        = clear_cnt;
                wd3_nxt       = '0;
                clear_cnt_nxt = clear_cnt + 1'b1;
                wait_cnt_nxt  = '0;
                if (clear_cnt == LAST_ADDR)
                    state_nxt = ST_ARB;
            end
            default: begin
                core_ready_o = !forced;
                dbg_ready_o  = forced || !core_we_i;
                core_hs      = core_we_i && core_ready_o;
                dbg_hs       = dbg_valid_i && dbg_ready_o;
                // x0 is hard-wired: the handshake completes but no write strobe is issued
                if (core_hs) begin
                    we_nxt  = (core_addr_i != '0);
                    a3_nxt  = core_addr_i;
                    wd3_nxt = core_data_i;
                end else if (dbg_hs) begin
                    we_nxt  = (dbg_addr_i != '0);
                    a3_nxt  = dbg_addr_i;
                    wd3_nxt = dbg_data_i;
                end
                if (dbg_hs || !dbg_valid_i)
                    wait_cnt_nxt = '0;
                else if (!dbg_ready_o && !forced)
                    wait_cnt_nxt = wait_cnt + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= RESET_STATE;
            clear_cnt           <= SIZE'(1);
            wait_cnt            <= '0;
            reg_write_WE3_o     <= 1'b0;
            write_register_A3_o <= '0;
            write_data_WD3_o    <= '0;
        end else begin
            state               <= state_nxt;
            clear_cnt           <= clear_cnt_nxt;
            wait_cnt            <= wait_cnt_nxt;
            reg_write_WE3_o     <= we_nxt;
            write_register_A3_o <= a3_nxt;
            write_data_WD3_o    <= wd3_nxt;
        end
    end
endmodule

// File: tb/tb_reg_file_write_scheduler.sv
// Bench for reg_file_write_scheduler: cycle model checked every negedge, directed scenarios with literal expectations.
module tb_reg_file_write_scheduler;
    localparam int WIDTH = 32;
    localparam int SIZE  = 5;
    localparam int LIM   = 4;
    localparam int NREG  = 1 << SIZE;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    logic             core_we = 0, dbg_valid = 0;
    logic [SIZE-1:0]  core_addr = 0, dbg_addr = 0;
    logic [WIDTH-1:0] core_data = 0, dbg_data = 0;
    logic             core_rdy, dbg_rdy, we3, busy;
    logic [SIZE-1:0]  a3;
    logic [WIDTH-1:0] wd3;

    logic             c2_we = 0, d2_valid = 0;
    logic [SIZE-1:0]  c2_addr = 0, d2_addr = 0;
    logic [WIDTH-1:0] c2_data = 0, d2_data = 0;
    logic             c2_rdy, d2_rdy, we3_2, busy_2;
    logic [SIZE-1:0]  a3_2;
    logic [WIDTH-1:0] wd3_2;

    reg_file_write_scheduler #(.WIDTH(WIDTH), .SIZE(SIZE), .CLEAR_ON_RESET(1), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .core_we_i(core_we), .core_addr_i(core_addr), .core_data_i(core_data), .core_ready_o(core_rdy),
        .dbg_valid_i(dbg_valid), .dbg_addr_i(dbg_addr), .dbg_data_i(dbg_data), .dbg_ready_o(dbg_rdy),
        .reg_write_WE3_o(we3), .write_register_A3_o(a3), .write_data_WD3_o(wd3), .busy_o(busy));

    reg_file_write_scheduler #(.WIDTH(WIDTH), .SIZE(SIZE), .CLEAR_ON_RESET(0), .STARVE_LIMIT(LIM)) dut2 (
        .clk(clk), .reset(reset),
        .core_we_i(c2_we), .core_addr_i(c2_addr), .core_data_i(c2_data), .core_ready_o(c2_rdy),
        .dbg_valid_i(d2_valid), .dbg_addr_i(d2_addr), .dbg_data_i(d2_data), .dbg_ready_o(d2_rdy),
        .reg_write_WE3_o(we3_2), .write_register_A3_o(a3_2), .write_data_WD3_o(wd3_2), .busy_o(busy_2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sweep progress, consecutive refused debug cycles, and the write expected on the port.
    bit          m_sweeping;
    int          m_next_addr;
    int          m_lost;
    bit          m_we;
    int          m_a3;
    logic [31:0] m_wd3;
    bit          core_hs_m, dbg_hs_m;

    always @(negedge clk) begin
        bit e_core, e_dbg;
        if (reset) begin
            m_sweeping = 1; m_next_addr = 1; m_lost = 0;
            m_we = 0; m_a3 = 0; m_wd3 = 0;
            core_hs_m = 0; dbg_hs_m = 0;
            chk("rst_we3", we3, 0);
            chk("rst_a3", a3, 0);
            chk("rst_wd3", wd3, 0);
            chk("rst_busy", busy, 1);
            chk("rst_core_rdy", core_rdy, 0);
            chk("rst_dbg_rdy", dbg_rdy, 0);
        end else begin
            e_core = !m_sweeping && (m_lost < LIM);
            e_dbg  = !m_sweeping && ((m_lost >= LIM) || !core_we);
            chk("mdl_we3", we3, m_we);
            if (m_we) begin
                chk("mdl_a3", a3, m_a3);
                chk("mdl_wd3", wd3, m_wd3);
            end
            chk("mdl_busy", busy, m_sweeping);
            chk("mdl_core_rdy", core_rdy, e_core);
            chk("mdl_dbg_rdy", dbg_rdy, e_dbg);
            core_hs_m = core_we && e_core;
            dbg_hs_m  = dbg_valid && e_dbg;
            if (m_sweeping) begin
                m_we = 1; m_a3 = m_next_addr; m_wd3 = 0;
                if (m_next_addr == NREG - 1) m_sweeping = 0;
                m_next_addr++;
                m_lost = 0;
            end else begin
                if (core_hs_m) begin
                    m_we = (core_addr != 0); m_a3 = core_addr; m_wd3 = core_data;
                end else if (dbg_hs_m) begin
                    m_we = (dbg_addr != 0); m_a3 = dbg_addr; m_wd3 = dbg_data;
                end else begin
                    m_we = 0;
                end
                if (dbg_hs_m || !dbg_valid) m_lost = 0;
                else if (m_lost < LIM) m_lost++;
            end
        end
    end

    initial begin
        int n;
        d2_valid = 1; d2_addr = 31; d2_data = 6;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy_rst", busy_2, 0);
        reset = 0;
        #1;
        chk("t6_dbg_rdy", d2_rdy, 1);

        // T1: sweep A3 = 1..31 with WD3 = 0; busy drops on the edge issuing 31
        for (int i = 1; i < NREG; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                chk("t6_we3", we3_2, 1);
                chk("t6_a3", a3_2, 31);
                chk("t6_wd3", wd3_2, 6);
                d2_valid = 0;
            end
            if (i == 2) chk("t6_we3_off", we3_2, 0);
            chk("t1_a3", a3, i);
            chk("t1_we3", we3, 1);
            chk("t1_wd3", wd3, 0);
            chk("t1_busy", busy, (i == NREG - 1) ? 0 : 1);
        end

        // T2: single core write
        core_we = 1; core_addr = 2; core_data = 7;
        #1 chk("t2_core_rdy", core_rdy, 1);
        @(posedge clk); #1;
        core_we = 0;
        chk("t2_we3", we3, 1);
        chk("t2_a3", a3, 2);
        chk("t2_wd3", wd3, 7);

        // T3: continuous core traffic starves debug until the forced slot
        @(posedge clk); #1;
        core_we = 1; core_addr = 9; core_data = 32'h55;
        dbg_valid = 1; dbg_addr = 4; dbg_data = 20;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (dbg_rdy) break;
            n++;
            @(posedge clk); #1;
        end
        chk("t3_lost_cycles", n, 4);
        chk("t3_core_rdy_forced", core_rdy, 0);
        @(posedge clk); #1;
        chk("t3_we3", we3, 1);
        chk("t3_a3", a3, 4);
        chk("t3_wd3", wd3, 20);
        dbg_valid = 0; core_we = 0;

        // T4: write to x0 handshakes but issues no strobe
        @(posedge clk); #1;
        core_we = 1; core_addr = 0; core_data = 32'hFFFF_FFFF;
        #1 chk("t4_core_rdy", core_rdy, 1);
        @(posedge clk); #1;
        core_we = 0;
        chk("t4_we3", we3, 0);

        // random traffic; requesters hold until the model sees their handshake
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (!core_we || core_hs_m) begin
                core_we   = ($urandom_range(0, 99) < 55);
                core_addr = SIZE'($urandom);
                core_data = $urandom;
            end
            if (!dbg_valid || dbg_hs_m) begin
                dbg_valid = ($urandom_range(0, 99) < 50);
                dbg_addr  = SIZE'($urandom);
                dbg_data  = $urandom;
            end
        end
        @(posedge clk); #1;
        core_we = 0; dbg_valid = 0;

        // T5: reset mid-sweep restarts it from A3 = 1
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("t5_a3_pre", a3, i);
        end
        reset = 1;
        #1;
        chk("t5_we3_abort", we3, 0);
        chk("t5_a3_abort", a3, 0);
        chk("t5_busy_abort", busy, 1);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1;
        chk("t5_a3_restart", a3, 1);
        chk("t5_we3_restart", we3, 1);
        repeat (NREG - 2) @(posedge clk);
        #1 chk("t5_busy_done", busy, 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
